// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: sequences PLL reset/power-down and qualifies lock before releasing downstream logic
// Ports: clk, rst (sync, active high), pwrdwn_req (level), restart (pulse), pll_locked (async)
//        -> pll_rst, pll_pwrdwn, ready, failed, lost_lock (pulse), retries[3:0]
// Build option: define PLL_LOCK_CTRL_AUTORELOCK_EN to relock automatically after loss of lock
//               (otherwise loss of lock lands in FAIL).
module pll_lock_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNTR_WIDTH    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwrdwn_req,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       pll_pwrdwn,
  output logic       ready,
  output logic       failed,
  output logic       lost_lock,
  output logic [3:0] retries
);
  typedef enum logic [2:0] {S_RESET, S_WAIT, S_STABLE, S_RUN, S_FAIL, S_PWRDN} state_t;
  localparam logic [CNTR_WIDTH-1:0] RST_LAST = CNTR_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNTR_WIDTH-1:0] TO_LAST  = CNTR_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNTR_WIDTH-1:0] ST_LAST  = CNTR_WIDTH'(STABLE_CYCLES - 1);
  state_t state, state_n;
  logic [CNTR_WIDTH-1:0] cnt, cnt_n;
  logic [1:0] sync;
  logic [3:0] retries_n;
  logic lock_s, fresh, enter, failed_n, lost_n;
  assign lock_s = sync[1];
  always_comb begin
    state_n   = state;
    enter     = 1'b0;
    retries_n = retries;
    failed_n  = failed;
    lost_n    = 1'b0;
    if (pwrdwn_req) begin
      state_n = S_PWRDN;
      enter   = state != S_PWRDN;
    end else if (state == S_PWRDN) begin
      state_n = S_RESET;
      enter   = 1'b1;
    end else if (restart) begin
      state_n   = S_RESET;
      enter     = 1'b1;
      retries_n = '0;
      failed_n  = 1'b0;
    end else begin
      case (state)
        // fresh holds off the exit so the pulse counts from the first edge out of rst
        S_RESET: if (cnt == RST_LAST && !fresh) begin
          state_n = S_WAIT;
          enter   = 1'b1;
        end
        S_WAIT: if (lock_s) begin
          state_n = S_STABLE;
          enter   = 1'b1;
        end else if (cnt == TO_LAST) begin
          enter = 1'b1;
          if (retries == 4'(MAX_RETRIES)) begin
            state_n  = S_FAIL;
            failed_n = 1'b1;
          end else begin
            state_n   = S_RESET;
            retries_n = (retries == 4'hf) ? retries : retries + 4'd1;
          end
        end
        S_STABLE: if (!lock_s) begin
          state_n = S_WAIT;
          enter   = 1'b1;
        end else if (cnt == ST_LAST) begin
          state_n = S_RUN;
          enter   = 1'b1;
        end
        S_RUN: if (!lock_s) begin
          lost_n = 1'b1;
          enter  = 1'b1;
`ifdef PLL_LOCK_CTRL_AUTORELOCK_EN
          state_n = S_RESET;
`else
          state_n  = S_FAIL;
          failed_n = 1'b1;
`endif
        end
        default: ;
      endcase
    end
    if (enter && state_n == S_RESET) failed_n = 1'b0;
    // counter only runs in the timed states so it never wraps while parked
    cnt_n = enter ? '0 : (fresh || !(state inside {S_RESET, S_WAIT, S_STABLE})) ? cnt : cnt + CNTR_WIDTH'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RESET;
      cnt        <= '0;
      sync       <= '0;
      fresh      <= 1'b1;
      retries    <= '0;
      failed     <= 1'b0;
      lost_lock  <= 1'b0;
      pll_rst    <= 1'b1;
      pll_pwrdwn <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sync       <= {sync[0], pll_locked};
      fresh      <= 1'b0;
      retries    <= retries_n;
      failed     <= failed_n;
      lost_lock  <= lost_n;
      pll_rst    <= state_n inside {S_RESET, S_FAIL, S_PWRDN};
      pll_pwrdwn <= state_n == S_PWRDN;
      ready      <= state_n == S_RUN;
    end
  end
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed and randomized checks of pll_lock_ctrl against a phase/age reference model
module tb_pll_lock_ctrl;
  localparam int R = 4, T = 100, S = 8, M = 2;
  localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4, P_PWRDN = 5;
  logic clk = 0, rst = 1, pwrdwn_req = 0, restart = 0, pll_locked = 0;
  logic pll_rst, pll_pwrdwn, ready, failed, lost_lock;
  logic [3:0] retries;
  int tests = 0, fails = 0;
  pll_lock_ctrl #(.RST_CYCLES(R), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S), .MAX_RETRIES(M), .CNTR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .pwrdwn_req(pwrdwn_req), .restart(restart), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .pll_pwrdwn(pll_pwrdwn), .ready(ready), .failed(failed),
    .lost_lock(lost_lock), .retries(retries)
  );
  always #5 clk = ~clk;
  int ph = P_RESET, age = -1, m_ret = 0;
  bit m_fail = 0, m_lost = 0, chk_en = 0;
  bit hist[2] = '{0, 0};
  task go(input int p);
    ph = p;
    age = 0;
    if (p == P_RESET) m_fail = 0;
  endtask
  always @(posedge clk) begin
    bit lk;
    int n;
    lk = hist[1];
    m_lost = 0;
    if (rst) begin
      ph = P_RESET;
      age = -1;
      m_ret = 0;
      m_fail = 0;
      hist[0] = 0;
      hist[1] = 0;
      chk_en = 1;
    end else begin
      n = age + 1;
      if (pwrdwn_req) begin
        if (ph != P_PWRDN) go(P_PWRDN);
      end else if (ph == P_PWRDN) go(P_RESET);
      else if (restart) begin
        m_ret = 0;
        m_fail = 0;
        go(P_RESET);
      end else if (ph == P_RESET) begin
        if (n >= R) go(P_WAIT); else age = n;
      end else if (ph == P_WAIT) begin
        if (lk) go(P_STABLE);
        else if (n >= T) begin
          if (m_ret == M) begin
            m_fail = 1;
            go(P_FAIL);
          end else begin
            m_ret = (m_ret < 15) ? m_ret + 1 : 15;
            go(P_RESET);
          end
        end else age = n;
      end else if (ph == P_STABLE) begin
        if (!lk) go(P_WAIT); else if (n >= S) go(P_RUN); else age = n;
      end else if (ph == P_RUN && !lk) begin
        m_lost = 1;
`ifdef PLL_LOCK_CTRL_AUTORELOCK_EN
        go(P_RESET);
`else
        m_fail = 1;
        go(P_FAIL);
`endif
      end
      hist[1] = hist[0];
      hist[0] = pll_locked;
    end
  end
  task automatic cmp(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    cmp("model pll_rst", int'(pll_rst), int'(ph == P_RESET || ph == P_FAIL || ph == P_PWRDN));
    cmp("model pll_pwrdwn", int'(pll_pwrdwn), int'(ph == P_PWRDN));
    cmp("model ready", int'(ready), int'(ph == P_RUN));
    cmp("model failed", int'(failed), int'(m_fail));
    cmp("model lost_lock", int'(lost_lock), int'(m_lost));
    cmp("model retries", int'(retries), m_ret);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic run_len(input logic v, output int n);
    n = 0;
    while (pll_rst === v && n < 300) begin
      n++;
      tick(1);
    end
  endtask
  task automatic edges_until(input bit want_lost, output int k);
    k = 0;
    while (!(want_lost ? lost_lock === 1'b1 : ready === 1'b1) && k < 300) begin
      tick(1);
      k++;
    end
  endtask
  task automatic check_reset_vals(input string tag);
    cmp({tag, " pll_rst"}, int'(pll_rst), 1);
    cmp({tag, " pll_pwrdwn"}, int'(pll_pwrdwn), 0);
    cmp({tag, " ready"}, int'(ready), 0);
    cmp({tag, " failed"}, int'(failed), 0);
    cmp({tag, " lost_lock"}, int'(lost_lock), 0);
    cmp({tag, " retries"}, int'(retries), 0);
  endtask
  initial begin
    int n, k, seen;
    tick(3);
    check_reset_vals("reset");
    rst = 0;
    tick(1);
    run_len(1'b1, n);
    cmp("nominal rst pulse", n, 4);
    tick(15);
    pll_locked = 1;
    edges_until(0, k);
    cmp("nominal ready latency", k, 11);
    cmp("nominal retries", int'(retries), 0);
    pll_locked = 0;
    edges_until(1, k);
    cmp("loss latency", k, 3);
    cmp("loss ready low", int'(ready), 0);
`ifdef PLL_LOCK_CTRL_AUTORELOCK_EN
    run_len(1'b1, n);
    cmp("relock rst pulse", n, 4);
    cmp("relock lost_lock pulse", int'(lost_lock), 0);
`else
    tick(1);
    cmp("loss pulse width", int'(lost_lock), 0);
    cmp("loss failed", int'(failed), 1);
    cmp("loss pll_rst", int'(pll_rst), 1);
`endif
    restart = 1;
    tick(1);
    restart = 0;
    cmp("restart failed", int'(failed), 0);
    run_len(1'b1, n);
    cmp("restart rst pulse", n, 4);
    for (int i = 1; i <= 3; i++) begin
      run_len(1'b0, n);
      cmp("timeout wait", n, 100);
      if (i < 3) begin
        cmp("timeout retries", int'(retries), i);
        run_len(1'b1, n);
        cmp("timeout rst pulse", n, 4);
      end
    end
    cmp("fail failed", int'(failed), 1);
    cmp("fail pll_rst", int'(pll_rst), 1);
    cmp("fail retries", int'(retries), 2);
    restart = 1;
    tick(1);
    restart = 0;
    cmp("restart2 failed", int'(failed), 0);
    cmp("restart2 retries", int'(retries), 0);
    run_len(1'b1, n);
    cmp("restart2 rst pulse", n, 4);
    pll_locked = 1;
    tick(5);
    pll_locked = 0;
    seen = 0;
    repeat (12) begin
      tick(1);
      if (ready) seen++;
    end
    cmp("glitch no ready", seen, 0);
    pll_locked = 1;
    edges_until(0, k);
    cmp("glitch ready latency", k, 11);
    pwrdwn_req = 1;
    tick(1);
    cmp("pwrdn pll_pwrdwn", int'(pll_pwrdwn), 1);
    cmp("pwrdn pll_rst", int'(pll_rst), 1);
    cmp("pwrdn ready", int'(ready), 0);
    tick(9);
    cmp("pwrdn held", int'(pll_pwrdwn), 1);
    pwrdwn_req = 0;
    tick(1);
    cmp("pwrdn release", int'(pll_pwrdwn), 0);
    run_len(1'b1, n);
    cmp("pwrdn rst pulse", n, 4);
    edges_until(0, k);
    cmp("pwrdn relock", k, 9);
    restart = 1;
    pwrdwn_req = 1;
    tick(1);
    restart = 0;
    cmp("prio pll_pwrdwn", int'(pll_pwrdwn), 1);
    cmp("prio ready", int'(ready), 0);
    tick(2);
    pwrdwn_req = 0;
    tick(1);
    run_len(1'b1, n);
    cmp("prio rst pulse", n, 4);
    tick(1);
    rst = 1;
    pll_locked = 0;
    tick(1);
    check_reset_vals("rst in stable");
    rst = 0;
    tick(1);
    run_len(1'b1, n);
    cmp("post-rst pulse", n, 4);
    tick(97);
    pll_locked = 1;
    seen = 0;
    k = 0;
    while (ready !== 1'b1 && k < 300) begin
      tick(1);
      k++;
      if (pll_rst) seen++;
    end
    cmp("lock beats timeout latency", k, 11);
    cmp("lock beats timeout no reset", seen, 0);
    cmp("lock beats timeout retries", int'(retries), 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) pll_locked = ~pll_locked;
      pwrdwn_req = pwrdwn_req ? ($urandom_range(9) != 0) : ($urandom_range(149) == 0);
      restart = ($urandom_range(199) == 0);
      rst = ($urandom_range(699) == 0);
      tick(1);
    end
    rst = 0;
    restart = 0;
    pwrdwn_req = 0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
